sparc_exu_eclrdpipe: RTL and testbench

- Destination-register pipeline for the integer ECL; sits directly upstream of the per-operand bypass logic.
- Carries rd, tid and write-enable of each issued instruction through E, M and W.
- Applies kill, stall-bubble, flush and %g0 suppression.
- Produces the stage rd/tid, thread-match and bypass-qualify signals that the bypass comparators consume; also drives the IRF write port controls at W.

---
 rtl/sparc_exu_eclrdpipe.sv | 75 +++++++
 tb/tb_sparc_exu_eclrdpipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sparc_exu_eclrdpipe.sv
// Destination-register pipeline D->E->M->W for the integer ECL.
// Feeds the bypass comparators and drives the IRF write port at W.
module sparc_exu_eclrdpipe #(
   parameter int NTHR_BITS = 2,
   parameter int NREG_BITS = 5
) (
   input  logic                 rclk,
   input  logic                 arst_l,
   input  logic [NTHR_BITS-1:0] tid_d,
   input  logic [NREG_BITS-1:0] rd_d,
   input  logic                 wen_d,
   input  logic                 longlat_d,
   input  logic                 hold_d,
   input  logic                 ifu_exu_kill_e,
   input  logic                 flush_w,
   output logic [NREG_BITS-1:0] rd_e,
   output logic [NREG_BITS-1:0] rd_m,
   output logic [NREG_BITS-1:0] ecl_irf_rd_w,
   output logic [NTHR_BITS-1:0] tid_e,
   output logic [NTHR_BITS-1:0] tid_m,
   output logic [NTHR_BITS-1:0] ecl_irf_tid_w,
   output logic                 thr_match_de,
   output logic                 thr_match_dm,
   output logic                 wb_e,
   output logic                 bypass_m,
   output logic                 bypass_w,
   output logic                 ecl_irf_wen_w
);

   logic wen_e;
   logic wen_m;
   logic wen_w;
   logic longlat_e;
   logic longlat_m;
   logic wen_d_eff;

   // Writes to %g0 are dropped before they enter the pipe.
   assign wen_d_eff = wen_d & (rd_d != '0);

   always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
         rd_e          <= '0;
         rd_m          <= '0;
         ecl_irf_rd_w  <= '0;
         tid_e         <= '0;
         tid_m         <= '0;
         ecl_irf_tid_w <= '0;
         wen_e         <= 1'b0;
         wen_m         <= 1'b0;
         wen_w         <= 1'b0;
         longlat_e     <= 1'b0;
         longlat_m     <= 1'b0;
      end else begin
         rd_e          <= rd_d;
         tid_e         <= tid_d;
         longlat_e     <= longlat_d;
         wen_e         <= wen_d_eff & ~hold_d;
         rd_m          <= rd_e;
         tid_m         <= tid_e;
         longlat_m     <= longlat_e;
         wen_m         <= wen_e & ~ifu_exu_kill_e;
         ecl_irf_rd_w  <= rd_m;
         ecl_irf_tid_w <= tid_m;
         wen_w         <= wen_m;
      end
   end

   assign wb_e          = wen_e;
   assign bypass_m      = wen_m & ~longlat_m;
   assign bypass_w      = wen_w & ~flush_w;
   assign ecl_irf_wen_w = wen_w & ~flush_w;
   assign thr_match_de  = (tid_d == tid_e);
   assign thr_match_dm  = (tid_d == tid_m);

endmodule

// File: tb/tb_sparc_exu_eclrdpipe.sv
// Scoreboard bench for sparc_exu_eclrdpipe.
// Instruction records flow through a queue; a monitor checks stage views.
module tb_sparc_exu_eclrdpipe;

   typedef struct packed {
      logic [4:0] rd;
      logic [1:0] tid;
      logic       wen;
      logic       ll;
      logic       hold;
      logic       kill;
      logic       flush;
   } instr_t;

   logic       rclk;
   logic       arst_l;
   logic [1:0] tid_d;
   logic [4:0] rd_d;
   logic       wen_d;
   logic       longlat_d;
   logic       hold_d;
   logic       ifu_exu_kill_e;
   logic       flush_w;
   logic [4:0] rd_e;
   logic [4:0] rd_m;
   logic [4:0] ecl_irf_rd_w;
   logic [1:0] tid_e;
   logic [1:0] tid_m;
   logic [1:0] ecl_irf_tid_w;
   logic       thr_match_de;
   logic       thr_match_dm;
   logic       wb_e;
   logic       bypass_m;
   logic       bypass_w;
   logic       ecl_irf_wen_w;

   int errors = 0;
   int checks = 0;
   bit mon_en = 0;

   instr_t hist[$];
   instr_t sbq[$];

   sparc_exu_eclrdpipe #(.NTHR_BITS(2), .NREG_BITS(5)) dut (
      .rclk(rclk), .arst_l(arst_l),
      .tid_d(tid_d), .rd_d(rd_d), .wen_d(wen_d),
      .longlat_d(longlat_d), .hold_d(hold_d),
      .ifu_exu_kill_e(ifu_exu_kill_e), .flush_w(flush_w),
      .rd_e(rd_e), .rd_m(rd_m), .ecl_irf_rd_w(ecl_irf_rd_w),
      .tid_e(tid_e), .tid_m(tid_m), .ecl_irf_tid_w(ecl_irf_tid_w),
      .thr_match_de(thr_match_de), .thr_match_dm(thr_match_dm),
      .wb_e(wb_e), .bypass_m(bypass_m), .bypass_w(bypass_w),
      .ecl_irf_wen_w(ecl_irf_wen_w)
   );

   initial rclk = 0;
   always #5 rclk = ~rclk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit writes(input instr_t i);
      return i.wen && (i.rd != 0) && !i.hold;
   endfunction

   // Monitor: sbq holds [W, M, E, D] after each advance.
   always @(negedge rclk) begin
      if (mon_en) begin
         instr_t w, m, e, d;
         while (sbq.size() > 4) void'(sbq.pop_front());
         if (sbq.size() == 4) begin
            w = sbq[0]; m = sbq[1]; e = sbq[2]; d = sbq[3];
            chk("wb_e", wb_e, writes(e));
            chk("rd_e", rd_e, e.rd);
            chk("tid_e", tid_e, e.tid);
            chk("bypass_m", bypass_m, writes(m) && !m.kill && !m.ll);
            chk("rd_m", rd_m, m.rd);
            chk("tid_m", tid_m, m.tid);
            chk("irf_wen_w", ecl_irf_wen_w,
                writes(w) && !w.kill && !w.flush);
            chk("bypass_w", bypass_w, writes(w) && !w.kill && !w.flush);
            chk("irf_rd_w", ecl_irf_rd_w, w.rd);
            chk("irf_tid_w", ecl_irf_tid_w, w.tid);
            chk("thr_de", thr_match_de, d.tid == e.tid);
            chk("thr_dm", thr_match_dm, d.tid == m.tid);
         end
      end
   end

   task automatic pipe_init();
      instr_t z;
      z = '0;
      hist.delete();
      sbq.delete();
      repeat (3) begin
         hist.push_back(z);
         sbq.push_back(z);
      end
   endtask

   // Called just after a posedge; drives D and the E/W side controls.
   task automatic issue(input int rd, input int tid, input bit wen,
                        input bit ll, input bit hold, input bit kill,
                        input bit flush);
      instr_t i;
      i.rd = 5'(rd); i.tid = 2'(tid); i.wen = wen; i.ll = ll;
      i.hold = hold; i.kill = kill; i.flush = flush;
      hist.push_back(i);
      sbq.push_back(i);
      rd_d           = i.rd;
      tid_d          = i.tid;
      wen_d          = i.wen;
      longlat_d      = i.ll;
      hold_d         = i.hold;
      ifu_exu_kill_e = hist[hist.size()-2].kill;
      flush_w        = hist[hist.size()-4].flush;
      @(posedge rclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) issue(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      arst_l = 0;
      rd_d = 5; tid_d = 2; wen_d = 1;
      longlat_d = 0; hold_d = 0;
      ifu_exu_kill_e = 0; flush_w = 0;
      repeat (3) begin
         @(negedge rclk);
         chk("rst_wb_e", wb_e, 0);
         chk("rst_bypass_m", bypass_m, 0);
         chk("rst_bypass_w", bypass_w, 0);
         chk("rst_irf_wen", ecl_irf_wen_w, 0);
         chk("rst_rd_e", rd_e, 0);
         chk("rst_thr_de", thr_match_de, 0);
      end
      @(posedge rclk);
      #1;
      arst_l = 1;
      pipe_init();
      mon_en = 1;

      issue(5, 2, 1, 0, 0, 0, 0);
      idle(4);
      issue(0, 1, 1, 0, 0, 0, 0);
      idle(4);
      issue(3, 0, 1, 0, 0, 0, 0);
      issue(7, 0, 1, 0, 1, 0, 0);
      idle(4);
      issue(9, 1, 1, 0, 0, 1, 0);
      issue(10, 1, 1, 0, 0, 0, 0);
      idle(4);
      issue(12, 2, 1, 1, 0, 0, 0);
      idle(4);
      issue(12, 2, 1, 1, 0, 0, 1);
      idle(4);
      issue(4, 3, 1, 0, 0, 0, 0);
      issue(6, 1, 1, 0, 0, 0, 0);
      issue(8, 1, 1, 0, 0, 0, 0);
      idle(3);

      for (int n = 0; n < 400; n++) begin
         int r;
         r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
         issue(r, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      end
      idle(3);

      // Asynchronous reset while a bypassable write sits in M.
      issue(11, 1, 1, 0, 0, 0, 0);
      issue(13, 2, 1, 0, 0, 0, 0);
      mon_en = 0;
      #2;
      chk("pre_arst_bypass_m", bypass_m, 1);
      arst_l = 0;
      #1;
      chk("arst_bypass_m", bypass_m, 0);
      chk("arst_wb_e", wb_e, 0);
      chk("arst_irf_wen", ecl_irf_wen_w, 0);
      chk("arst_rd_m", rd_m, 0);
      @(posedge rclk);
      #1;
      arst_l = 1;
      pipe_init();
      mon_en = 1;
      issue(14, 3, 1, 0, 0, 0, 0);
      idle(4);
      mon_en = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
